// File: rtl/l2_arbiter.sv
// l2_arbiter: two-client arbiter in front of the L2 cache.
// Merges I-cache read misses and D-cache read misses / writebacks onto the
// single l2arb_mem_* port. The granted request is registered and held stable
// until the L2 responds. The returned line then goes back to the owning
// client with a one-cycle resp pulse. Ties alternate between the clients.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_*                   I-cache side (read only)
//   dmem_*                   D-cache side (read and writeback)
//   l2arb_mem_*              request port into the L2
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | evaluate pending requests, grant one and latch it
// BUSY  | drive latched request to L2 until l2arb_mem_resp
// DONE  | one-cycle resp pulse to the owner, L2 request deasserted
module l2_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] imem_address,
    input  logic                  imem_read,
    output logic [LINE_WIDTH-1:0] imem_rdata,
    output logic                  imem_resp,
    input  logic [ADDR_WIDTH-1:0] dmem_address,
    input  logic                  dmem_read,
    input  logic                  dmem_write,
    input  logic [LINE_WIDTH-1:0] dmem_wdata,
    output logic [LINE_WIDTH-1:0] dmem_rdata,
    output logic                  dmem_resp,
    output logic [ADDR_WIDTH-1:0] l2arb_mem_address,
    output logic                  l2arb_mem_read,
    output logic                  l2arb_mem_write,
    output logic [LINE_WIDTH-1:0] l2arb_mem_wdata,
    input  logic [LINE_WIDTH-1:0] l2arb_mem_rdata,
    input  logic                  l2arb_mem_resp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LINE_WIDTH-1:0] req_wdata;
    logic [LINE_WIDTH-1:0] rdata_reg;
    logic                  req_op;      // 1 = write
    logic                  owner;       // 1 = D-cache
    logic                  last_grant;  // 1 = D-cache

    logic i_pend;
    logic d_pend;
    logic grant_valid;
    logic grant_d;

    always_comb begin
        i_pend      = imem_read;
        d_pend      = dmem_read | dmem_write;
        grant_valid = i_pend | d_pend;
        // On a tie the client that did not win last time goes next.
        grant_d     = d_pend & (~i_pend | ~last_grant);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (l2arb_mem_resp) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic: everything is decoded from registers, so the client and
    // L2 handshakes never have a combinational path between them.
    always_comb begin
        l2arb_mem_read    = 1'b0;
        l2arb_mem_write   = 1'b0;
        imem_resp         = 1'b0;
        dmem_resp         = 1'b0;
        l2arb_mem_address = req_addr;
        l2arb_mem_wdata   = req_wdata;
        imem_rdata        = rdata_reg;
        dmem_rdata        = rdata_reg;
        case (state)
            BUSY: begin
                l2arb_mem_read  = ~req_op;
                l2arb_mem_write = req_op;
            end
            DONE: begin
                imem_resp = ~owner;
                dmem_resp = owner;
            end
            default: begin
            end
        endcase
    end

    // Request / response datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr   <= '0;
            req_wdata  <= '0;
            rdata_reg  <= '0;
            req_op     <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b0;
        end else begin
            if (state == IDLE && grant_valid) begin
                req_addr   <= grant_d ? dmem_address : imem_address;
                // A write wins if the D-cache raises read and write together.
                req_op     <= grant_d & dmem_write;
                owner      <= grant_d;
                last_grant <= grant_d;
                if (grant_d && dmem_write) begin
                    req_wdata <= dmem_wdata;
                end
            end
            if (state == BUSY && l2arb_mem_resp) begin
                rdata_reg <= l2arb_mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
module tb_l2_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  imem_address;
    logic         imem_read;
    logic [127:0] imem_rdata;
    logic         imem_resp;
    logic [15:0]  dmem_address;
    logic         dmem_read;
    logic         dmem_write;
    logic [127:0] dmem_wdata;
    logic [127:0] dmem_rdata;
    logic         dmem_resp;
    logic [15:0]  l2arb_mem_address;
    logic         l2arb_mem_read;
    logic         l2arb_mem_write;
    logic [127:0] l2arb_mem_wdata;
    logic [127:0] l2arb_mem_rdata;
    logic         l2arb_mem_resp;

    int errors = 0;
    int checks = 0;

    // Reference model state: who won the previous grant, and the last line
    // delivered back from the L2.
    bit           last_was_d;
    logic [127:0] last_line;

    l2_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_address      (imem_address),
        .imem_read         (imem_read),
        .imem_rdata        (imem_rdata),
        .imem_resp         (imem_resp),
        .dmem_address      (dmem_address),
        .dmem_read         (dmem_read),
        .dmem_write        (dmem_write),
        .dmem_wdata        (dmem_wdata),
        .dmem_rdata        (dmem_rdata),
        .dmem_resp         (dmem_resp),
        .l2arb_mem_address (l2arb_mem_address),
        .l2arb_mem_read    (l2arb_mem_read),
        .l2arb_mem_write   (l2arb_mem_write),
        .l2arb_mem_wdata   (l2arb_mem_wdata),
        .l2arb_mem_rdata   (l2arb_mem_rdata),
        .l2arb_mem_resp    (l2arb_mem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full transaction, entered just after a rising edge with the DUT
    // idle. Returns just after the rising edge that brings it back to idle.
    task automatic run_txn(input bit i_req, input bit d_req, input bit d_wr,
                           input bit d_both, input bit drop, input bit scramble,
                           input int lat, input logic [15:0] ai, input logic [15:0] ad,
                           input logic [127:0] wd, input logic [127:0] line);
        bit           win_d;
        bit           exp_wr;
        logic [15:0]  exp_addr;
        imem_read    = i_req;
        imem_address = ai;
        dmem_read    = d_req & (~d_wr | d_both);
        dmem_write   = d_req & d_wr;
        dmem_address = ad;
        dmem_wdata   = wd;

        win_d      = d_req && (!i_req || !last_was_d);
        last_was_d = win_d;
        exp_wr     = win_d && d_wr;
        exp_addr   = win_d ? ad : ai;

        @(negedge clk);
        chk("idle_read", l2arb_mem_read, 1'b0);
        chk("idle_resp", {imem_resp, dmem_resp}, 2'b00);
        @(posedge clk); #1;

        for (int c = 1; c <= lat; c++) begin
            if (drop && c == 1) begin
                if (win_d) begin dmem_read = 0; dmem_write = 0; end
                else imem_read = 0;
            end
            if (scramble) begin
                dmem_address = 16'($urandom);
                dmem_wdata   = rand_line();
            end
            l2arb_mem_resp  = (c == lat);
            l2arb_mem_rdata = (c == lat) ? line : rand_line();
            @(negedge clk);
            chk("busy_read", l2arb_mem_read, !exp_wr);
            chk("busy_write", l2arb_mem_write, exp_wr);
            chk("busy_addr", l2arb_mem_address, exp_addr);
            if (exp_wr) chk("busy_wdata", l2arb_mem_wdata, wd);
            chk("busy_resp", {imem_resp, dmem_resp}, 2'b00);
            @(posedge clk); #1;
        end

        l2arb_mem_resp  = 1'b0;
        l2arb_mem_rdata = rand_line();
        if (win_d) begin dmem_read = 0; dmem_write = 0; end
        else imem_read = 0;
        last_line = line;
        @(negedge clk);
        chk("done_imem_resp", imem_resp, !win_d);
        chk("done_dmem_resp", dmem_resp, win_d);
        chk("done_l2_rw", {l2arb_mem_read, l2arb_mem_write}, 2'b00);
        chk("done_imem_rdata", imem_rdata, line);
        chk("done_dmem_rdata", dmem_rdata, line);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [127:0] a5_line;
        logic [127:0] wb_line;
        a5_line = {16{8'hA5}};
        wb_line = 128'h0123456789ABCDEF0123456789ABCDEF;

        rst = 1; imem_read = 0; imem_address = 0; dmem_read = 0; dmem_write = 0;
        dmem_address = 0; dmem_wdata = 0; l2arb_mem_rdata = 0; l2arb_mem_resp = 0;
        last_was_d = 0; last_line = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_rw", {l2arb_mem_read, l2arb_mem_write}, 2'b00);
        chk("rst_resp", {imem_resp, dmem_resp}, 2'b00);
        chk("rst_addr", l2arb_mem_address, 16'h0);
        chk("rst_wdata", l2arb_mem_wdata, 128'h0);
        chk("rst_rdata", imem_rdata, 128'h0);
        @(posedge clk); #1;

        // I-only read, L2 answers in the 2nd BUSY cycle
        run_txn(1, 0, 0, 0, 0, 0, 2, 16'h1230, 16'h0, 0, a5_line);
        // D writeback
        run_txn(0, 1, 1, 0, 0, 0, 1, 16'h0, 16'h4440, wb_line, rand_line());

        // Ties after a fresh reset: D first, then I, then D again
        rst = 1; @(posedge clk); #1 rst = 0;
        last_was_d = 0;
        run_txn(1, 1, 0, 0, 0, 0, 1, 16'h1111, 16'h2222, 0, rand_line());
        run_txn(1, 0, 0, 0, 0, 0, 1, 16'h1111, 16'h0, 0, rand_line());
        run_txn(1, 1, 0, 0, 0, 0, 2, 16'h3333, 16'h4444, 0, rand_line());

        // Sustained contention: grants alternate
        for (int n = 0; n < 6; n++) begin
            run_txn(1, 1, n[0], 0, 0, 0, int'($urandom_range(1, 4)),
                    16'($urandom) & 16'h7FFF, 16'($urandom) | 16'h8000, rand_line(), rand_line());
        end
        imem_read = 0; dmem_read = 0; dmem_write = 0;

        // Illegal read+write together: write is performed
        run_txn(0, 1, 1, 1, 0, 0, 2, 16'h0, 16'h5550, rand_line(), rand_line());
        // Client drops its request mid-BUSY: response still delivered
        run_txn(1, 0, 0, 0, 1, 0, 3, 16'h6660, 16'h0, 0, rand_line());
        // dmem inputs wiggle during BUSY: latched values must hold
        run_txn(0, 1, 1, 0, 0, 1, 4, 16'h0, 16'h7770, rand_line(), rand_line());

        // Random traffic
        for (int n = 0; n < 20; n++) begin
            bit ir, dr;
            ir = 1'($urandom);
            dr = 1'($urandom) | ~ir;
            run_txn(ir, dr, 1'($urandom), 0, 0, 1'($urandom), int'($urandom_range(1, 5)),
                    16'($urandom), 16'($urandom), rand_line(), rand_line());
            imem_read = 0; dmem_read = 0; dmem_write = 0;
        end

        // L2 resp while idle is ignored
        l2arb_mem_resp = 1; l2arb_mem_rdata = ~last_line;
        @(negedge clk);
        chk("stray_resp_rw", {l2arb_mem_read, l2arb_mem_write}, 2'b00);
        @(posedge clk); #1;
        l2arb_mem_resp = 0;
        @(negedge clk);
        chk("stray_resp_client", {imem_resp, dmem_resp}, 2'b00);
        chk("stray_resp_rdata", imem_rdata, last_line);
        @(posedge clk); #1;

        // Reset during the 3rd BUSY cycle abandons the transaction
        imem_read = 1; imem_address = 16'h0AB0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_busy", l2arb_mem_read, 1'b1);
        rst = 1; imem_read = 0;
        @(posedge clk); #1 rst = 0;
        last_was_d = 0; last_line = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_read", l2arb_mem_read, 1'b0);
            chk("post_rst_resp", {imem_resp, dmem_resp}, 2'b00);
            chk("post_rst_rdata", dmem_rdata, 128'h0);
            @(posedge clk); #1;
        end
        run_txn(1, 0, 0, 0, 0, 0, 1, 16'h0BC0, 16'h0, 0, rand_line());
        // First tie after that reset goes to D
        run_txn(1, 1, 1, 0, 0, 0, 1, 16'h0CC0, 16'h0DD0, rand_line(), rand_line());
        imem_read = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
